// File: rtl/tuner_pkg.sv
// Shared constants for the tuner: noise-shaping modes, LFSR definition, pipeline latency.
package tuner_pkg;

   typedef enum logic [1:0] {
      NS_OFF    = 2'd0,
      NS_EF     = 2'd1,
      NS_DITHER = 2'd2,
      NS_RSVD   = 2'd3
   } ns_mode_e;

   localparam int unsigned LFSR_W    = 16;
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   // Galois form of x^16+x^14+x^13+x^11+1, right-shifting
   localparam logic [15:0] LFSR_TAPS = 16'hB400;
   localparam int unsigned LATENCY   = 4;

   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
   endfunction

endpackage

// File: rtl/tuner_nco_lut.sv
// Quarter-wave sine ROM with quadrant fold; registered sin/cos of the phase, 1-cycle latency.
module tuner_nco_lut #(
   parameter int unsigned psz = 12,
   parameter int unsigned lsz = 12
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [psz-1:0]        phs,
   output logic signed [lsz-1:0] cos_val,
   output logic signed [lsz-1:0] sin_val
);

   localparam int unsigned QN = 2 ** (psz - 2);
   localparam int unsigned MW = lsz - 1;
   localparam int unsigned AW = psz - 1;
   localparam logic [MW-1:0]  PEAK = '1;
   localparam logic [AW-1:0]  QADDR = AW'(QN);
   localparam logic [psz-1:0] QTR = psz'(QN);
   localparam longint PI_HALF_Q30 = 64'sd1686629713;

   // Elaboration-time sine: Taylor series in Q30, rounded to the LUT amplitude
   function automatic int quarter_sin(input int k);
      longint x;
      longint t;
      longint s;
      x = (longint'(k) * PI_HALF_Q30) >>> (psz - 2);
      t = x;
      s = x;
      for (int n = 1; n <= 6; n++) begin
         t = -((((t * x) >>> 30) * x) >>> 30) / longint'((2 * n) * (2 * n + 1));
         s = s + t;
      end
      return int'((s * longint'(PEAK) + (longint'(1) << 29)) >>> 30);
   endfunction

   logic [MW-1:0] rom [QN];

   for (genvar k = 0; k < QN; k++) begin : g_rom
      localparam int V = quarter_sin(k);
      assign rom[k] = MW'(V);
   end

   // Mirror the index in odd quadrants; the value at exactly a quarter turn is the peak
   function automatic logic [AW-1:0] fold_addr(input logic [psz-1:0] p);
      return p[psz-2] ? (QADDR - {1'b0, p[psz-3:0]}) : {1'b0, p[psz-3:0]};
   endfunction

   logic [psz-1:0] phs_c;
   logic [AW-1:0]  a_s;
   logic [AW-1:0]  a_c;
   logic [MW-1:0]  m_s;
   logic [MW-1:0]  m_c;

   always_comb begin
      phs_c = phs + QTR;
      a_s   = fold_addr(phs);
      a_c   = fold_addr(phs_c);
      m_s   = a_s[AW-1] ? PEAK : rom[a_s[AW-2:0]];
      m_c   = a_c[AW-1] ? PEAK : rom[a_c[AW-2:0]];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sin_val <= '0;
         cos_val <= '0;
      end else begin
         sin_val <= phs[psz-1]   ? -{1'b0, m_s} : {1'b0, m_s};
         cos_val <= phs_c[psz-1] ? -{1'b0, m_c} : {1'b0, m_c};
      end
   end

endmodule

// File: rtl/tuner_3.sv
// Real-to-complex tuner: NCO with retune handshake, phase noise shaping and a 4-stage I/Q mixer.
module tuner_3
   import tuner_pkg::*;
#(
   parameter int unsigned dsz = 10,
   parameter int unsigned fsz = 26,
   parameter int unsigned psz = 12,
   parameter int unsigned lsz = 12
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic signed [dsz-1:0] in,
   input  logic                  in_valid,
   input  logic [fsz-1:0]        frq_data,
   input  logic                  frq_load,
   output logic                  frq_ack,
   input  logic [psz-1:0]        phs_ofs,
   input  logic [1:0]            ns_mode,
   input  logic                  acc_clr,
   output logic signed [dsz-1:0] i_out,
   output logic signed [dsz-1:0] q_out,
   output logic                  out_valid
);

   localparam int unsigned RSZ = fsz - psz;
   localparam int unsigned PW  = dsz + lsz;
   localparam logic signed [PW-1:0] HALF = PW'(1) << (lsz - 2);
   localparam logic signed [PW-1:0] OMAX = PW'((1 << (dsz - 1)) - 1);

   logic [fsz-1:0]        acc;
   logic [fsz-1:0]        ns_acc;
   logic [fsz-1:0]        frq;
   logic [fsz-1:0]        frq_stage;
   logic                  frq_pend;
   logic [LFSR_W-1:0]     lfsr;
   logic [psz-1:0]        ofs_d;
   logic [psz-1:0]        phs;
   logic signed [dsz-1:0] in_d [3];
   logic [2:0]            vld;
   logic signed [lsz-1:0] cos_val;
   logic signed [lsz-1:0] sin_val;
   logic [RSZ-1:0]        res;

   assign res = ns_acc[RSZ-1:0];

   // S1: retune handshake, phase accumulator, noise shaping
   always_ff @(posedge clk) begin
      if (reset) begin
         acc       <= '0;
         ns_acc    <= '0;
         frq       <= '0;
         frq_stage <= '0;
         frq_pend  <= 1'b0;
         frq_ack   <= 1'b0;
         lfsr      <= LFSR_SEED;
         ofs_d     <= '0;
      end else begin
         frq_ack <= 1'b0;
         if (frq_load) begin
            frq_stage <= frq_data;
            frq_pend  <= 1'b1;
         end
         if (in_valid) begin
            // A fresh load on the same sample defers the switch to the next sample
            if (frq_pend && !frq_load) begin
               frq      <= frq_stage;
               frq_pend <= 1'b0;
               frq_ack  <= 1'b1;
            end
            acc <= acc_clr ? '0 : acc + frq;
            case (ns_mode_e'(ns_mode))
               NS_EF:     ns_acc <= acc + {{psz{res[RSZ-1]}}, res};
               NS_DITHER: ns_acc <= acc + {{psz{1'b0}}, lfsr[RSZ-1:0]};
               default:   ns_acc <= acc;
            endcase
            lfsr  <= lfsr_next(lfsr);
            ofs_d <= phs_ofs;
         end
      end
   end

   // S1..S3 sample alignment and S2 phase add
   always_ff @(posedge clk) begin
      if (reset) begin
         in_d[0] <= '0;
         in_d[1] <= '0;
         in_d[2] <= '0;
         vld     <= '0;
         phs     <= '0;
      end else begin
         in_d[0] <= in;
         in_d[1] <= in_d[0];
         in_d[2] <= in_d[1];
         vld     <= {vld[1:0], in_valid};
         phs     <= ns_acc[fsz-1 -: psz] + ofs_d;
      end
   end

   // S3: sine/cosine lookup
   tuner_nco_lut #(.psz(psz), .lsz(lsz)) u_lut (
      .clk     (clk),
      .reset   (reset),
      .phs     (phs),
      .cos_val (cos_val),
      .sin_val (sin_val)
   );

   function automatic logic signed [dsz-1:0] round_sat(input logic signed [PW-1:0] p);
      logic signed [PW-1:0] r;
      r = (p + HALF) >>> (lsz - 1);
      if (r > OMAX)  return dsz'(OMAX);
      if (r < -OMAX) return dsz'(-OMAX);
      return r[dsz-1:0];
   endfunction

   logic signed [PW-1:0] prod_i;
   logic signed [PW-1:0] prod_q;

   always_comb begin
      prod_i = PW'(in_d[2]) * PW'(cos_val);
      prod_q = PW'(in_d[2]) * PW'(sin_val);
   end

   // S4: round, saturate, hold between valid samples
   always_ff @(posedge clk) begin
      if (reset) begin
         i_out     <= '0;
         q_out     <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= vld[2];
         if (vld[2]) begin
            i_out <= round_sat(prod_i);
            q_out <= round_sat(prod_q);
         end
      end
   end

endmodule
